// File: rtl/conv_post_pkg.sv
// Shared widths, pool FSM state type and the ReLU/round/saturate requantiser
// for the conv array post-processing stage.
package conv_post_pkg;

  localparam int unsigned PSUM_W = 16;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned ACC_W  = 18;

  typedef enum logic {StEven, StOdd} pool_state_e;

  // ReLU, round-half-up right shift, saturate to OUT_W bits.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] s1,
                                               input logic [3:0]              shift_amt);
    logic [ACC_W:0] half;
    logic [ACC_W:0] rounded;
    logic [ACC_W:0] shifted;
    if (s1[ACC_W-1]) begin
      return '0;
    end
    half    = (shift_amt == 4'd0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (shift_amt - 4'd1));
    rounded = {1'b0, s1} + half;
    shifted = rounded >> shift_amt;
    if (shifted > {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}}) begin
      return '1;
    end
    return shifted[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read straight from the
// storage array. A push while full is accepted only if a pop happens too.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_post_pool.sv
// Post-processing for the 1-D conv array: bias, ReLU/requantise, optional 2:1
// max-pool and a small output FIFO. The input side never stalls.
module conv_post_pool #(
  parameter int unsigned PSUM_W     = 16,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              last_in,
  input  logic [15:0]       bias,
  input  logic [3:0]        shift_amt,
  input  logic              pool_en,
  input  logic              ovf_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              ovf
);
  import conv_post_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                    s1_valid_q, s1_last_q;
  logic signed [ACC_W-1:0] s1_q;
  logic                    s2_valid_q, s2_last_q;
  logic [OUT_W-1:0]        s2_data_q;

  pool_state_e             state_q, state_d;
  logic [OUT_W-1:0]        held_q, held_d;
  logic                    push, push_last, pop, drop;
  logic [OUT_W-1:0]        push_data;
  logic                    ovf_q, ovf_d;

  logic [OUT_W:0]          fifo_head;
  logic                    fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= valid_in;
      s2_valid_q <= s1_valid_q;
      if (valid_in) begin
        s1_last_q <= last_in;
        s1_q      <= {{(ACC_W - PSUM_W){1'b0}}, psum_in} + {{(ACC_W - 16){bias[15]}}, bias};
      end
      if (s1_valid_q) begin
        s2_last_q <= s1_last_q;
        s2_data_q <= requant(s1_q, shift_amt);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    push      = 1'b0;
    push_data = s2_data_q;
    push_last = s2_last_q;
    if (s2_valid_q) begin
      if (!pool_en) begin
        push    = 1'b1;
        state_d = StEven;
      end else begin
        unique case (state_q)
          StEven: begin
            if (s2_last_q) begin
              push = 1'b1;
            end else begin
              held_d  = s2_data_q;
              state_d = StOdd;
            end
          end
          StOdd: begin
            push      = 1'b1;
            push_data = (held_q > s2_data_q) ? held_q : s2_data_q;
            state_d   = StEven;
          end
          default: state_d = StEven;
        endcase
      end
    end
  end

  assign pop  = out_valid && out_ready;
  // The FSM advances even when the result is dropped.
  assign drop = push && fifo_full && !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEven;
      held_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_last, push_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[OUT_W-1:0];
  assign out_last  = fifo_head[OUT_W];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_conv_post_pool.sv
// Directed bench for conv_post_pool: single-element vector table plus
// hand-written pooling, backpressure and reset sequences.
module tb_conv_post_pool;

  logic        clk, rst;
  logic        valid_in, last_in, pool_en, ovf_clr, out_ready;
  logic [15:0] psum_in, bias;
  logic [3:0]  shift_amt;
  logic        out_valid, out_last, ovf;
  logic [7:0]  out_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } out_t;
  out_t got[$];

  typedef struct {
    logic [15:0] bias;
    logic [3:0]  shift;
    logic [15:0] psum;
    logic        last;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [16];

  conv_post_pool dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .psum_in   (psum_in),
    .last_in   (last_in),
    .bias      (bias),
    .shift_amt (shift_amt),
    .pool_en   (pool_en),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so the negedge sees a stable handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back('{d: out_data, l: out_last});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] p, input logic l);
    valid_in = 1'b1;
    psum_in  = p;
    last_in  = l;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_n(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic take(input string name, input logic [7:0] d, input logic l);
    out_t item;
    if (got.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no output, expected data %0d", name, d);
    end else begin
      item = got.pop_front();
      chk({name, " data"}, 32'(item.d), 32'(d));
      chk({name, " last"}, 32'(item.l), 32'(l));
    end
  endtask

  initial begin
    vecs[0]  = '{16'd0,       4'd0,  16'd20,    1'b0, 8'd20};
    vecs[1]  = '{16'd0,       4'd2,  16'd6,     1'b1, 8'd2};
    vecs[2]  = '{16'd0,       4'd2,  16'd1000,  1'b0, 8'd250};
    vecs[3]  = '{16'd0,       4'd2,  16'd1023,  1'b0, 8'd255};
    vecs[4]  = '{16'd0,       4'd2,  16'd1024,  1'b1, 8'd255};
    vecs[5]  = '{-16'sd50,    4'd0,  16'd20,    1'b0, 8'd0};
    vecs[6]  = '{-16'sd50,    4'd0,  16'd80,    1'b1, 8'd30};
    vecs[7]  = '{16'd0,       4'd1,  16'd5,     1'b0, 8'd3};
    vecs[8]  = '{16'd0,       4'd1,  16'd4,     1'b0, 8'd2};
    vecs[9]  = '{16'd100,     4'd4,  16'd65535, 1'b0, 8'd255};
    vecs[10] = '{16'h8000,    4'd0,  16'd32900, 1'b1, 8'd132};
    vecs[11] = '{16'h7fff,    4'd15, 16'd65535, 1'b0, 8'd3};
    vecs[12] = '{16'hffff,    4'd3,  16'd0,     1'b0, 8'd0};
    vecs[13] = '{16'd0,       4'd8,  16'd65407, 1'b0, 8'd255};
    vecs[14] = '{16'd0,       4'd8,  16'd65279, 1'b1, 8'd255};
    vecs[15] = '{16'd0,       4'd8,  16'd65151, 1'b0, 8'd254};

    rst = 1'b1; valid_in = 1'b0; psum_in = '0; last_in = 1'b0; bias = '0;
    shift_amt = '0; pool_en = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    #3;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset ovf", 32'(ovf), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bias      = vecs[i].bias;
      shift_amt = vecs[i].shift;
      drive(vecs[i].psum, vecs[i].last);
      wait_n(1);
      take($sformatf("vec%0d", i), vecs[i].exp, vecs[i].last);
    end

    // Basic pooling with latency check on the first output
    bias = '0; shift_amt = '0; pool_en = 1'b1;
    drive(16'd20, 1'b0);
    drive(16'd26, 1'b0);
    chk("pool lat E0", 32'(out_valid), 0);
    drive(16'd32, 1'b0);
    chk("pool lat E1", 32'(out_valid), 0);
    drive(16'd38, 1'b1);
    chk("pool lat E2", 32'(out_valid), 1);
    wait_n(2);
    take("pool first", 8'd26, 1'b0);
    take("pool second", 8'd38, 1'b1);

    // Negative bias through the pool
    bias = -16'sd50;
    drive(16'd20, 1'b0);
    drive(16'd80, 1'b1);
    wait_n(1);
    take("relu pool", 8'd30, 1'b1);

    // Odd-length row, then an even row to show the FSM is back in EVEN
    bias = '0;
    drive(16'd5, 1'b0);
    drive(16'd9, 1'b0);
    drive(16'd7, 1'b1);
    wait_n(2);
    take("odd pair", 8'd9, 1'b0);
    take("odd tail", 8'd7, 1'b1);
    drive(16'd4, 1'b0);
    drive(16'd8, 1'b1);
    wait_n(1);
    take("after odd", 8'd8, 1'b1);

    // Backpressure and overflow
    pool_en = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) drive(16'(i), i == 6);
    repeat (4) @(posedge clk);
    #1;
    chk("bp ovf set", 32'(ovf), 1);
    chk("bp head", 32'(out_data), 1);
    @(posedge clk);
    #1;
    chk("bp head stable", 32'(out_data), 1);
    out_ready = 1'b1;
    wait_n(4);
    take("drain 1", 8'd1, 1'b0);
    take("drain 2", 8'd2, 1'b0);
    take("drain 3", 8'd3, 1'b0);
    take("drain 4", 8'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp no extra", got.size(), 0);
    chk("bp empty", 32'(out_valid), 0);
    chk("bp ovf sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("ovf cleared", 32'(ovf), 0);

    // Mid-row asynchronous reset
    pool_en = 1'b1; out_ready = 1'b0;
    drive(16'd10, 1'b0);
    drive(16'd11, 1'b0);
    drive(16'd12, 1'b0);
    drive(16'd13, 1'b0);
    drive(16'd14, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset valid", 32'(out_valid), 1);
    chk("pre-reset head", 32'(out_data), 11);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset valid", 32'(out_valid), 0);
    chk("async reset data", 32'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(16'd4, 1'b0);
    drive(16'd8, 1'b1);
    wait_n(1);
    take("post-reset", 8'd8, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("post-reset single", got.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
